// File: rtl/arduino_byte_fifo_if.sv
// Parallel-bus and drain-side signals of the Arduino byte FIFO.
interface arduino_byte_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic                  STROBE;
  logic [7:0]            DATA_IN;
  logic                  ENABLE;
  logic                  CLEAR_OVERFLOW;
  logic                  START_TRANSFER;
  logic [7:0]            TRANSFER_BYTE;
  logic [DEPTH_LOG2:0]   FIFO_COUNT;
  logic                  OVERFLOW;
  logic                  ACTIVITY;

  // Arduino / control-register side
  modport master (
    output STROBE, DATA_IN, ENABLE, CLEAR_OVERFLOW,
    input  START_TRANSFER, TRANSFER_BYTE, FIFO_COUNT, OVERFLOW, ACTIVITY
  );

  // FIFO side
  modport slave (
    input  STROBE, DATA_IN, ENABLE, CLEAR_OVERFLOW,
    output START_TRANSFER, TRANSFER_BYTE, FIFO_COUNT, OVERFLOW, ACTIVITY
  );
endinterface

// File: rtl/arduino_byte_fifo.sv
// Captures strobed Arduino bytes into a small FIFO and drains them one at a
// time into active_transfer with a programmable gap between start pulses.
module arduino_byte_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic                 CLK,
  input  logic                 RST,
  arduino_byte_fifo_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             start_q, start_d;
  logic [7:0]       byte_q, byte_d;
  logic             activity_q, activity_d;

  logic             push_c;
  logic             push_ok_c;
  logic             pop_c;
  logic             full_c;

  // Next-state logic: strobe synchroniser, FIFO bookkeeping and drain FSM
  always_comb begin
    s1_d       = bus.STROBE;
    s2_d       = s1_q;
    s3_d       = s2_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    start_d    = start_q;
    byte_d     = byte_q;
    pop_c      = 1'b0;

    // One push per strobe high period; full judged on the pre-edge count
    push_c    = s2_q & ~s3_q;
    full_c    = (count_q == CNT_W'(DEPTH));
    push_ok_c = push_c & ~full_c;

    if (push_ok_c) begin
      mem_d[wr_ptr_q] = bus.DATA_IN;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    // Clear first so that a drop in the same cycle wins
    if (bus.CLEAR_OVERFLOW) begin
      overflow_d = 1'b0;
    end
    if (push_c && full_c) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.ENABLE && (count_q != '0)) begin
          byte_d   = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          pop_c    = 1'b1;
          start_d  = 1'b1;
          state_d  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        start_d   = 1'b0;
        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    count_d    = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    activity_d = (count_d != '0) | (state_d != ST_IDLE);
  end

  // State registers; reset discards FIFO contents and aborts any pulse or gap
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      start_q    <= 1'b0;
      byte_q     <= 8'h00;
      activity_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      start_q    <= start_d;
      byte_q     <= byte_d;
      activity_q <= activity_d;
    end
  end

  assign bus.START_TRANSFER = start_q;
  assign bus.TRANSFER_BYTE  = byte_q;
  assign bus.FIFO_COUNT     = count_q;
  assign bus.OVERFLOW       = overflow_q;
  assign bus.ACTIVITY       = activity_q;

endmodule

// File: tb/tb_arduino_byte_fifo.sv
// Directed bench for arduino_byte_fifo (depth 4, gap 4).
module tb_arduino_byte_fifo;

  localparam int unsigned DL2 = 2;
  localparam int unsigned GAP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   pulse_cnt = 0;
  int   base = 0;
  int   w = 0;
  logic [7:0] rec [$];
  logic [7:0] expq [$];
  logic [7:0] b;

  arduino_byte_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  arduino_byte_fifo #(
    .DEPTH_LOG2(DL2),
    .GAP_CYCLES(GAP)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Record every start pulse and the byte it carries
  always @(negedge clk) begin
    if (bus.START_TRANSFER === 1'b1) begin
      pulse_cnt++;
      rec.push_back(bus.TRANSFER_BYTE);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic strobe_byte(input logic [7:0] v, input int hi = 3, input int lo = 4);
    bus.DATA_IN = v;
    bus.STROBE  = 1'b1;
    tick(hi);
    bus.STROBE  = 1'b0;
    tick(lo);
  endtask

  task automatic wait_pulse(input string tag, input logic [7:0] exp, input int limit,
                            output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (bus.START_TRANSFER !== 1'b1 && waited < limit);
    chk({tag, "_seen"}, 32'(bus.START_TRANSFER), 32'd1);
    chk({tag, "_byte"}, 32'(bus.TRANSFER_BYTE), 32'(exp));
  endtask

  initial begin
    bus.STROBE         = 1'b0;
    bus.DATA_IN        = 8'h00;
    bus.ENABLE         = 1'b0;
    bus.CLEAR_OVERFLOW = 1'b0;
    rst_n              = 1'b0;
    tick(2);

    // Reset state
    chk("rst_count", 32'(bus.FIFO_COUNT), 32'd0);
    chk("rst_start", 32'(bus.START_TRANSFER), 32'd0);
    chk("rst_byte", 32'(bus.TRANSFER_BYTE), 32'd0);
    chk("rst_ovf", 32'(bus.OVERFLOW), 32'd0);
    chk("rst_act", 32'(bus.ACTIVITY), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: single 5-cycle strobe with drain enabled
    bus.ENABLE  = 1'b1;
    bus.DATA_IN = 8'hA5;
    bus.STROBE  = 1'b1;
    tick(2);
    chk("t1_count_edge2", 32'(bus.FIFO_COUNT), 32'd0);
    tick();
    chk("t1_count_edge3", 32'(bus.FIFO_COUNT), 32'd1);
    chk("t1_act", 32'(bus.ACTIVITY), 32'd1);
    chk("t1_start_pre", 32'(bus.START_TRANSFER), 32'd0);
    tick();
    chk("t1_start", 32'(bus.START_TRANSFER), 32'd1);
    chk("t1_byte", 32'(bus.TRANSFER_BYTE), 32'hA5);
    chk("t1_count_pop", 32'(bus.FIFO_COUNT), 32'd0);
    tick();
    chk("t1_start_end", 32'(bus.START_TRANSFER), 32'd0);
    chk("t1_byte_hold", 32'(bus.TRANSFER_BYTE), 32'hA5);
    bus.STROBE = 1'b0;
    tick(20);
    chk("t1_pulses", 32'(pulse_cnt), 32'd1);
    chk("t1_byte_late", 32'(bus.TRANSFER_BYTE), 32'hA5);
    chk("t1_act_idle", 32'(bus.ACTIVITY), 32'd0);

    // 2: buffer three bytes while disabled, then drain with fixed spacing
    bus.ENABLE = 1'b0;
    strobe_byte(8'h01);
    strobe_byte(8'h02);
    strobe_byte(8'h03);
    chk("t2_count", 32'(bus.FIFO_COUNT), 32'd3);
    chk("t2_no_pulse", 32'(pulse_cnt), 32'd1);
    bus.ENABLE = 1'b1;
    wait_pulse("t2_b0", 8'h01, 10, w);
    wait_pulse("t2_b1", 8'h02, 20, w);
    chk("t2_gap1", 32'(w), 32'd6);
    wait_pulse("t2_b2", 8'h03, 20, w);
    chk("t2_gap2", 32'(w), 32'd6);
    tick(10);
    chk("t2_count_end", 32'(bus.FIFO_COUNT), 32'd0);
    chk("t2_act_end", 32'(bus.ACTIVITY), 32'd0);

    // 3: overflow when six bytes arrive into a depth-4 FIFO
    bus.ENABLE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe_byte(8'(8'h10 + i));
    end
    chk("t3_count", 32'(bus.FIFO_COUNT), 32'd4);
    chk("t3_ovf", 32'(bus.OVERFLOW), 32'd1);
    bus.CLEAR_OVERFLOW = 1'b1;
    tick();
    bus.CLEAR_OVERFLOW = 1'b0;
    chk("t3_ovf_clr", 32'(bus.OVERFLOW), 32'd0);
    base = pulse_cnt;
    bus.ENABLE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_pulse("t3_drain", 8'(8'h10 + i), 20, w);
    end
    tick(10);
    chk("t3_count_end", 32'(bus.FIFO_COUNT), 32'd0);
    chk("t3_pulses", 32'(pulse_cnt - base), 32'd4);

    // 4: a long strobe captures one byte only
    bus.ENABLE = 1'b0;
    strobe_byte(8'h5A, 50, 4);
    chk("t4_count", 32'(bus.FIFO_COUNT), 32'd1);
    bus.ENABLE = 1'b1;
    wait_pulse("t4_b", 8'h5A, 10, w);
    tick(10);
    chk("t4_count_end", 32'(bus.FIFO_COUNT), 32'd0);

    // 5: push into a full FIFO on the same edge as a pop is still dropped
    bus.ENABLE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      strobe_byte(8'(8'h20 + i));
    end
    chk("t5_full", 32'(bus.FIFO_COUNT), 32'd4);
    chk("t5_ovf_pre", 32'(bus.OVERFLOW), 32'd0);
    bus.DATA_IN = 8'h24;
    bus.STROBE  = 1'b1;
    tick(2);
    bus.ENABLE  = 1'b1;
    tick();
    chk("t5_count", 32'(bus.FIFO_COUNT), 32'd3);
    chk("t5_ovf", 32'(bus.OVERFLOW), 32'd1);
    chk("t5_start", 32'(bus.START_TRANSFER), 32'd1);
    chk("t5_byte", 32'(bus.TRANSFER_BYTE), 32'h20);
    bus.STROBE = 1'b0;
    for (int i = 1; i < 4; i++) begin
      wait_pulse("t5_drain", 8'(8'h20 + i), 20, w);
    end
    tick(10);
    chk("t5_count_end", 32'(bus.FIFO_COUNT), 32'd0);
    bus.CLEAR_OVERFLOW = 1'b1;
    tick();
    bus.CLEAR_OVERFLOW = 1'b0;
    chk("t5_ovf_clr", 32'(bus.OVERFLOW), 32'd0);

    // 6: reset during a gap, then random traffic with pointer wrap
    bus.ENABLE = 1'b0;
    strobe_byte(8'h30);
    strobe_byte(8'h31);
    strobe_byte(8'h32);
    bus.ENABLE = 1'b1;
    wait_pulse("t6_first", 8'h30, 10, w);
    tick(2);
    chk("t6_count_gap", 32'(bus.FIFO_COUNT), 32'd2);
    chk("t6_act_gap", 32'(bus.ACTIVITY), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(bus.FIFO_COUNT), 32'd0);
    chk("t6_rst_start", 32'(bus.START_TRANSFER), 32'd0);
    chk("t6_rst_byte", 32'(bus.TRANSFER_BYTE), 32'd0);
    chk("t6_rst_ovf", 32'(bus.OVERFLOW), 32'd0);
    chk("t6_rst_act", 32'(bus.ACTIVITY), 32'd0);
    tick(2);
    rst_n = 1'b1;
    base = pulse_cnt;
    tick(20);
    chk("t6_no_pulse", 32'(pulse_cnt - base), 32'd0);
    chk("t6_count_idle", 32'(bus.FIFO_COUNT), 32'd0);
    rec.delete();
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      expq.push_back(b);
      strobe_byte(b, 3, 3);
    end
    tick(30);
    chk("t6_rx_count", 32'(rec.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < rec.size()) begin
        chk("t6_rx_byte", 32'(rec[i]), 32'(expq[i]));
      end else begin
        chk("t6_rx_missing", 32'd0, 32'(expq[i]) | 32'h100);
      end
    end
    chk("t6_count_end", 32'(bus.FIFO_COUNT), 32'd0);
    chk("t6_ovf_end", 32'(bus.OVERFLOW), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
